// File: rtl/mux_tree_pipe.sv
// ---------------------------------------------------------------------------
// mux_tree_pipe
//
// Pipelined N:1 multiplexer tree (N = 2**SEL_W). Each pair of select bits,
// LSB pair first, drives one bank of radix-4 muxes that ends in a register
// stage. Every stage carries its narrowed candidate vector, the original
// select (echoed on out_sel) and a valid bit. A valid/ready handshake runs at
// both ends. Empty stages refill even while the output is stalled, so no
// transfer is lost or duplicated under back-pressure.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    N flattened lanes, lane i = in_data[i*DATA_W +: DATA_W]
//   in_sel     lane index for this transfer
//   in_valid   in_data / in_sel valid
//   in_ready   block accepts a transfer this cycle
//   out_data   selected lane
//   out_sel    in_sel value that produced out_data
//   out_valid  out_data / out_sel valid
//   out_ready  downstream accepts this cycle
//
// SEL_W must be even and at least 2; DATA_W must be at least 1.
// ---------------------------------------------------------------------------
module mux_tree_pipe #(
   parameter int DATA_W = 8,
   parameter int SEL_W  = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [(1<<SEL_W)*DATA_W-1:0] in_data,
   input  logic [SEL_W-1:0]             in_sel,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [DATA_W-1:0]            out_data,
   output logic [SEL_W-1:0]             out_sel,
   output logic                         out_valid,
   input  logic                         out_ready
);

   localparam int N      = 1 << SEL_W;
   localparam int LEVELS = SEL_W / 2;

   // Bit offset of level k's candidate register inside w_cand_flat.
   function automatic int lvl_off(input int k);
      int s = 0;
      for (int m = 0; m < k; m++) begin
         s += (N >> (2*m + 2)) * DATA_W;
      end
      return s;
   endfunction

   localparam int TOT_W = lvl_off(LEVELS);

   // Register outputs of every level, gathered so the next level can reach
   // them with constant slices.
   wire [TOT_W-1:0]        w_cand_flat;
   wire [LEVELS*SEL_W-1:0] w_sel_flat;
   wire [LEVELS-1:0]       w_v;
   wire [LEVELS-1:0]       w_load;

   genvar gi;
   genvar gj;

   generate
      for (gi = 0; gi < LEVELS; gi++) begin : g_lvl
         localparam int W_IN  = (N >> (2*gi)) * DATA_W;
         localparam int M_OUT = N >> (2*gi + 2);

         logic [W_IN-1:0]         w_cand_in;
         logic [SEL_W-1:0]        w_sel_in;
         logic                    w_up_v;
         logic [1:0]              w_s;
         wire  [M_OUT*DATA_W-1:0] w_mux;

         logic [M_OUT*DATA_W-1:0] r_cand;
         logic [SEL_W-1:0]        r_sel;
         logic                    r_v;

         if (gi == 0) begin : g_first
            assign w_cand_in = in_data;
            assign w_sel_in  = in_sel;
            // Loading stage 0 is exactly in_ready, so in_valid alone decides
            // whether the load carries a transfer.
            assign w_up_v    = in_valid;
         end else begin : g_next
            assign w_cand_in = w_cand_flat[lvl_off(gi-1) +: W_IN];
            assign w_sel_in  = w_sel_flat[(gi-1)*SEL_W +: SEL_W];
            assign w_up_v    = w_v[gi-1];
         end

         assign w_s = w_sel_in[2*gi +: 2];

         // Radix-4 bank: mux gj picks among candidates 4*gj .. 4*gj+3.
         for (gj = 0; gj < M_OUT; gj++) begin : g_mux
            logic [4*DATA_W-1:0] w_grp;
            logic [DATA_W-1:0]   w_pick;

            assign w_grp = w_cand_in[gj*4*DATA_W +: 4*DATA_W];

            always_comb begin
               w_pick = w_grp[0 +: DATA_W];
               case (w_s)
                  2'd1:    w_pick = w_grp[DATA_W   +: DATA_W];
                  2'd2:    w_pick = w_grp[2*DATA_W +: DATA_W];
                  2'd3:    w_pick = w_grp[3*DATA_W +: DATA_W];
                  default: w_pick = w_grp[0 +: DATA_W];
               endcase
            end

            assign w_mux[gj*DATA_W +: DATA_W] = w_pick;
         end

         // The recursive chain load[k] = !v[k] || load[k+1] (last: out_ready)
         // is flattened to an OR over this stage and every later one, which
         // keeps the ready path free of combinational feedback between bits.
         assign w_load[gi] = out_ready | ~(&w_v[LEVELS-1:gi]);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_v    <= 1'b0;
               r_cand <= '0;
               r_sel  <= '0;
            end else if (w_load[gi]) begin
               r_v <= w_up_v;
               // A bubble only clears valid; payload holds its old value.
               if (w_up_v) begin
                  r_cand <= w_mux;
                  r_sel  <= w_sel_in;
               end
            end
         end

         assign w_v[gi]                                 = r_v;
         assign w_cand_flat[lvl_off(gi) +: M_OUT*DATA_W] = r_cand;
         assign w_sel_flat[gi*SEL_W +: SEL_W]            = r_sel;
      end
   endgenerate

   // The last level narrows to a single lane at the top of w_cand_flat.
   assign out_data  = w_cand_flat[TOT_W-1 -: DATA_W];
   assign out_sel   = w_sel_flat[LEVELS*SEL_W-1 -: SEL_W];
   assign out_valid = w_v[LEVELS-1];
   assign in_ready  = w_load[0];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// ---------------------------------------------------------------------------
// tb_mux_tree_pipe
//
// Three instances of mux_tree_pipe: A (DATA_W 8, SEL_W 4), B (DATA_W 1,
// SEL_W 2) and C (DATA_W 16, SEL_W 6). Accepted inputs push the expected
// lane onto a per-instance queue; output transfers pop and compare.
// ---------------------------------------------------------------------------
module tb_mux_tree_pipe;

   localparam int AW = 8;
   localparam int AS = 4;
   localparam int AN = 16;
   localparam int BW = 1;
   localparam int BS = 2;
   localparam int BN = 4;
   localparam int CW = 16;
   localparam int CS = 6;
   localparam int CN = 64;

   typedef struct {
      logic [15:0] data;
      logic [5:0]  sel;
      int          cyc;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [AN*AW-1:0] a_in_data  = '0;
   logic [AS-1:0]    a_in_sel   = '0;
   logic             a_in_valid = 1'b0;
   logic             a_in_ready;
   logic [AW-1:0]    a_out_data;
   logic [AS-1:0]    a_out_sel;
   logic             a_out_valid;
   logic             a_out_ready = 1'b0;

   logic [BN*BW-1:0] b_in_data  = '0;
   logic [BS-1:0]    b_in_sel   = '0;
   logic             b_in_valid = 1'b0;
   logic             b_in_ready;
   logic [BW-1:0]    b_out_data;
   logic [BS-1:0]    b_out_sel;
   logic             b_out_valid;
   logic             b_out_ready = 1'b0;

   logic [CN*CW-1:0] c_in_data  = '0;
   logic [CS-1:0]    c_in_sel   = '0;
   logic             c_in_valid = 1'b0;
   logic             c_in_ready;
   logic [CW-1:0]    c_out_data;
   logic [CS-1:0]    c_out_sel;
   logic             c_out_valid;
   logic             c_out_ready = 1'b0;

   mux_tree_pipe #(.DATA_W(AW), .SEL_W(AS)) u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_data(a_in_data), .in_sel(a_in_sel), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .out_data(a_out_data), .out_sel(a_out_sel), .out_valid(a_out_valid), .out_ready(a_out_ready)
   );

   mux_tree_pipe #(.DATA_W(BW), .SEL_W(BS)) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_data(b_in_data), .in_sel(b_in_sel), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .out_data(b_out_data), .out_sel(b_out_sel), .out_valid(b_out_valid), .out_ready(b_out_ready)
   );

   mux_tree_pipe #(.DATA_W(CW), .SEL_W(CS)) u_dut_c (
      .clk(clk), .rst_n(rst_n),
      .in_data(c_in_data), .in_sel(c_in_sel), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .out_data(c_out_data), .out_sel(c_out_sel), .out_valid(c_out_valid), .out_ready(c_out_ready)
   );

   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];
   exp_t ea, eb, ec;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   bit   lat_a = 1'b0;
   bit   lat_b = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- output monitors (sampled on the falling edge) ----------
   always @(negedge clk) begin
      if (rst_n && a_out_valid && a_out_ready) begin
         n_vec++;
         if (qa.size() == 0) begin
            n_err++;
            $display("FAIL a_extra: out sel=%0d data=%h, required no output", a_out_sel, a_out_data);
         end else begin
            ea = qa.pop_front();
            if (a_out_data !== ea.data[AW-1:0] || a_out_sel !== ea.sel[AS-1:0]) begin
               n_err++;
               $display("FAIL a_data: got sel=%0d data=%h, required sel=%0d data=%h",
                        a_out_sel, a_out_data, ea.sel[AS-1:0], ea.data[AW-1:0]);
            end else if (lat_a && (cyc - ea.cyc) != AS/2) begin
               n_err++;
               $display("FAIL a_latency: got %0d cycles, required %0d", cyc - ea.cyc, AS/2);
            end else begin
               $display("A out: sel=%0d data=%h", a_out_sel, a_out_data);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && b_out_valid && b_out_ready) begin
         n_vec++;
         if (qb.size() == 0) begin
            n_err++;
            $display("FAIL b_extra: out sel=%0d data=%b, required no output", b_out_sel, b_out_data);
         end else begin
            eb = qb.pop_front();
            if (b_out_data !== eb.data[BW-1:0] || b_out_sel !== eb.sel[BS-1:0]) begin
               n_err++;
               $display("FAIL b_data: got sel=%0d data=%b, required sel=%0d data=%b",
                        b_out_sel, b_out_data, eb.sel[BS-1:0], eb.data[BW-1:0]);
            end else if (lat_b && (cyc - eb.cyc) != BS/2) begin
               n_err++;
               $display("FAIL b_latency: got %0d cycles, required %0d", cyc - eb.cyc, BS/2);
            end else begin
               $display("B out: sel=%0d data=%b", b_out_sel, b_out_data);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && c_out_valid && c_out_ready) begin
         n_vec++;
         if (qc.size() == 0) begin
            n_err++;
            $display("FAIL c_extra: out sel=%0d data=%h, required no output", c_out_sel, c_out_data);
         end else begin
            ec = qc.pop_front();
            if (c_out_data !== ec.data || c_out_sel !== ec.sel) begin
               n_err++;
               $display("FAIL c_data: got sel=%0d data=%h, required sel=%0d data=%h",
                        c_out_sel, c_out_data, ec.sel, ec.data);
            end else begin
               $display("C out: sel=%0d data=%h", c_out_sel, c_out_data);
            end
         end
      end
   end

   // ---------------- instance A drivers ----------------
   function automatic logic [AN*AW-1:0] rnd_a();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Drive one cycle of inputs (from posedge+1) and advance to the falling edge.
   task automatic a_set(input bit v, input logic [AS-1:0] s, input logic [AN*AW-1:0] d, input bit rdy);
      a_in_valid  = v;
      a_in_sel    = s;
      a_in_data   = d;
      a_out_ready = rdy;
      @(negedge clk);
   endtask

   // Record the handshake outcome of this cycle, then move past the next edge.
   task automatic a_push(output bit acc);
      exp_t e;
      acc = a_in_valid && a_in_ready;
      if (acc) begin
         e.data = '0;
         e.data[AW-1:0] = a_in_data[a_in_sel*AW +: AW];
         e.sel  = '0;
         e.sel[AS-1:0] = a_in_sel;
         e.cyc  = cyc;
         qa.push_back(e);
         $display("A in : sel=%0d lane=%h", a_in_sel, e.data[AW-1:0]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic a_drain(input string tag);
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      for (int i = 0; i < 40 && qa.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (qa.size() != 0) begin
         n_err++;
         $display("FAIL %s_drain: outstanding=%0d, required 0", tag, qa.size());
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      bit acc;
      #1;
      n_vec++;
      if (a_out_valid !== 1'b0 || a_out_data !== '0 || a_out_sel !== '0 || a_in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_init: valid=%b data=%h sel=%0d in_ready=%b, required 0/00/0/1",
                  a_out_valid, a_out_data, a_out_sel, a_in_ready);
      end
      n_vec++;
      if (b_out_valid !== 1'b0 || c_out_valid !== 1'b0 || b_in_ready !== 1'b1 || c_in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_bc: b_valid=%b c_valid=%b b_ready=%b c_ready=%b, required 0/0/1/1",
                  b_out_valid, c_out_valid, b_in_ready, c_in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Fill both stages with out_ready low; the third offer must be refused.
      a_set(1'b1, 4'd1, rnd_a(), 1'b0); a_push(acc);
      a_set(1'b1, 4'd2, rnd_a(), 1'b0); a_push(acc);
      a_set(1'b1, 4'd3, rnd_a(), 1'b0);
      n_vec++;
      if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL full_pipe: out_valid=%b in_ready=%b, required 1/0", a_out_valid, a_in_ready);
      end
      a_in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (a_out_valid !== 1'b0 || a_out_data !== '0 || a_out_sel !== '0 || a_in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_async: valid=%b data=%h sel=%0d in_ready=%b, required 0/00/0/1",
                  a_out_valid, a_out_data, a_out_sel, a_in_ready);
      end
      qa.delete();
      qb.delete();
      qc.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_select_sweep();
      logic [AN*AW-1:0] lanes;
      bit acc;
      for (int i = 0; i < AN; i++) lanes[i*AW +: AW] = 8'hA0 + 8'(i);
      lat_a = 1'b1;
      for (int i = 0; i < AN; i++) begin
         a_set(1'b1, 4'(i), lanes, 1'b1);
         a_push(acc);
         n_vec++;
         if (acc !== 1'b1) begin
            n_err++;
            $display("FAIL sweep_accept: sel=%0d accepted=%b, required 1", i, acc);
         end
      end
      a_drain("sweep");
      lat_a = 1'b0;
   endtask

   task automatic test_back_pressure();
      logic [AS-1:0]    sels [6] = '{4'd3, 4'd7, 4'd11, 4'd15, 4'd0, 4'd5};
      logic [AN*AW-1:0] dats [6];
      logic [AS+AW-1:0] held;
      int idx = 0;
      bit acc;
      for (int i = 0; i < 6; i++) dats[i] = rnd_a();
      for (int t = 0; t < 30 && idx < 6; t++) begin
         a_set(1'b1, sels[idx], dats[idx], !(t >= 3 && t < 7));
         if (t >= 3 && t < 7) begin
            n_vec++;
            if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin
               n_err++;
               $display("FAIL bp_stall: t=%0d in_ready=%b out_valid=%b, required 0/1", t, a_in_ready, a_out_valid);
            end
            if (t == 3) begin
               held = {a_out_sel, a_out_data};
            end else begin
               n_vec++;
               if ({a_out_sel, a_out_data} !== held) begin
                  n_err++;
                  $display("FAIL bp_hold: t=%0d got %h, required %h", t, {a_out_sel, a_out_data}, held);
               end
            end
         end
         a_push(acc);
         if (acc) idx++;
      end
      n_vec++;
      if (idx != 6) begin
         n_err++;
         $display("FAIL bp_accepted: got %0d transfers, required 6", idx);
      end
      a_drain("bp");
   endtask

   task automatic test_bubbles();
      bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      bit acc;
      lat_a = 1'b1;
      for (int i = 0; i < 6; i++) begin
         a_set(pat[i], 4'($urandom_range(0, AN-1)), rnd_a(), 1'b1);
         a_push(acc);
         n_vec++;
         if (acc !== pat[i]) begin
            n_err++;
            $display("FAIL bubble_accept: slot=%0d accepted=%b, required %b", i, acc, pat[i]);
         end
      end
      a_drain("bubbles");
      lat_a = 1'b0;
   endtask

   task automatic test_bubble_collapse();
      bit acc;
      a_set(1'b1, 4'd9, rnd_a(), 1'b0); a_push(acc);   // stage 0 full
      a_set(1'b0, 4'd0, rnd_a(), 1'b0); a_push(acc);   // moves into stage 1
      a_set(1'b1, 4'd12, rnd_a(), 1'b0);
      n_vec++;
      if (a_in_ready !== 1'b1 || a_out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL collapse_fill: in_ready=%b out_valid=%b, required 1/1", a_in_ready, a_out_valid);
      end
      a_push(acc);
      a_set(1'b1, 4'd6, rnd_a(), 1'b0);
      n_vec++;
      if (a_in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL collapse_full: in_ready=%b, required 0", a_in_ready);
      end
      a_in_valid = 1'b0;
      @(posedge clk);
      #1;
      a_drain("collapse");
   endtask

   task automatic test_variant_small();
      exp_t e;
      lat_b = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (i < 8) begin
            b_in_valid  = 1'b1;
            b_in_sel    = 2'(i % 4);
            b_in_data   = (i < 4) ? 4'b0110 : 4'b1001;
            b_out_ready = 1'b1;
         end else if (i < 10) begin
            b_in_valid  = 1'b0;
            b_out_ready = 1'b1;
         end else begin
            lat_b       = 1'b0;
            b_in_valid  = 1'($urandom_range(0, 1));
            b_in_sel    = 2'($urandom_range(0, BN-1));
            b_in_data   = 4'($urandom());
            b_out_ready = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         if (b_in_valid && b_in_ready) begin
            e.data = '0;
            e.data[0] = b_in_data[b_in_sel];
            e.sel  = '0;
            e.sel[BS-1:0] = b_in_sel;
            e.cyc  = cyc;
            qb.push_back(e);
            $display("B in : sel=%0d lane=%b", b_in_sel, e.data[0]);
         end
         @(posedge clk);
         #1;
      end
      b_in_valid  = 1'b0;
      b_out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      n_vec++;
      if (qb.size() != 0) begin
         n_err++;
         $display("FAIL b_drain: outstanding=%0d, required 0", qb.size());
      end
   endtask

   task automatic test_variant_random();
      exp_t e;
      int   n_acc = 0;
      for (int t = 0; t < 60000 && n_acc < 10000; t++) begin
         c_in_valid  = ($urandom_range(0, 3) != 0);
         c_in_sel    = 6'($urandom_range(0, CN-1));
         for (int k = 0; k < CN*CW/32; k++) c_in_data[k*32 +: 32] = $urandom();
         c_out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (c_in_valid && c_in_ready) begin
            e.data = c_in_data[c_in_sel*CW +: CW];
            e.sel  = c_in_sel;
            e.cyc  = cyc;
            qc.push_back(e);
            n_acc++;
            $display("C in : sel=%0d lane=%h", c_in_sel, e.data);
         end
         @(posedge clk);
         #1;
      end
      n_vec++;
      if (n_acc != 10000) begin
         n_err++;
         $display("FAIL c_throughput: got %0d transfers, required 10000", n_acc);
      end
      c_in_valid  = 1'b0;
      c_out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      n_vec++;
      if (qc.size() != 0) begin
         n_err++;
         $display("FAIL c_drain: outstanding=%0d, required 0", qc.size());
      end
   endtask

   initial begin
      test_reset();
      test_select_sweep();
      test_back_pressure();
      test_bubbles();
      test_bubble_collapse();
      test_variant_small();
      test_variant_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mux_tree_pipe.md
# mux_tree_pipe

Parametrised, pipelined N:1 multiplexer tree with one registered radix-4 level per pair of select bits and a valid/ready handshake at both ends. Selects one DATA_W-bit lane out of 2^SEL_W lanes at a throughput of one selection per cycle. Stalls losslessly under back-pressure. Successor to the fixed 16:1 combinational tree built from 4:1 muxes; used wherever a wide, deep selection must close timing at the system clock.

## Interface
- DATA_W, 8: width of each input lane and of out_data; must be at least 1.
- SEL_W, 4: select width; N = 2^SEL_W lanes; must be even and at least 2; LEVELS = SEL_W/2.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronised externally.
- in_data  input  N*DATA_W  flattened lanes; lane i = in_data[i*DATA_W +: DATA_W].
- in_sel  input  SEL_W  lane index for this transfer.
- in_valid  input  1  in_data/in_sel valid.
- in_ready  output  1  block accepts the transfer this cycle.
- out_data  output  DATA_W  selected lane.
- out_sel  output  SEL_W  echo of the in_sel value that produced out_data.
- out_valid  output  1  out_data/out_sel valid.
- out_ready  input  1  downstream accepts this cycle.

## Operation
- Level k, for k = 0..LEVELS-1, is a bank of N/4^(k+1) radix-4 muxes driven by select bits [2k+1:2k], LSB pair first. Lane grouping: level-0 mux j takes lanes 4j..4j+3.
- Each level ends in a register stage: candidate vector, remaining select bits [SEL_W-1:2k+2], the full original select (for out_sel), and a valid bit v[k].
- The last level's register drives out_data, out_sel and out_valid = v[LEVELS-1]. No combinational path from in_data to out_data.
- Stage k loads when load[k] = !v[k] || ready_k. ready_k = out_ready for the last stage and load[k+1] otherwise. in_ready = load[0].
- On load: v[k] takes the upstream valid (in_valid && in_ready for stage 0). Data and select registers update only when the upstream valid is 1. When the upstream valid is 0 they hold, and only v[k] clears.
- While v[k] = 1 and !ready_k, stage k holds all fields unchanged.
- Bubbles collapse: an empty stage loads even if downstream is stalled.
- in_ready depends combinationally on out_ready through the ready chain. This is accepted; there is no skid buffer.
- Input side, a transfer occurs when in_valid && in_ready. Output side, a transfer occurs when out_valid && out_ready.
- An upstream source may change in_sel/in_data while in_valid = 0 without effect.

## Timing
- Reset (rst_n = 0, asynchronous): all v[k] = 0; all data and select registers = 0. So out_valid = 0, out_data = 0, out_sel = 0, and in_ready = 1 immediately while in reset.
- Latency: LEVELS cycles from the accepting edge to out_valid = 1 (default SEL_W = 4: 2 cycles; SEL_W = 2: 1 cycle).
- Throughput: 1 transfer per cycle with out_ready held high. Order is strictly preserved, with no loss or duplication.
- Full pipe (all v = 1) with out_ready = 0: in_ready = 0 in the same cycle.
- Simultaneous out_ready = 1 and in_valid = 1 on a full pipe: both ends transfer in the same cycle.
- Reset mid-flight: all in-flight transfers are discarded. The first post-reset output is the first transfer accepted after rst_n rises.
- Select wrap: in_sel = N-1 selects the top lane. There is no out-of-range value.

## Test plan
- Reset: assert rst_n = 0 with the pipe full -> out_valid = 0, out_data = 0, out_sel = 0, in_ready = 1 asynchronously, without waiting for a clock edge.
- Select sweep (DATA_W = 8, SEL_W = 4): lane i = 8'hA0+i; send in_sel = 0..15 back-to-back with out_ready = 1 -> out_data = A0..AF in order, out_sel = 0..15, first out_valid 2 cycles after the first accept, no gaps.
- Back-pressure: stream 6 transfers with in_sel = 3,7,11,15,0,5 and hold out_ready = 0 for 4 cycles mid-stream -> in_ready falls once both stages are valid; outputs hold stable; all 6 emerge in order after release.
- Bubbles: in_valid pattern 1,0,1,0,0,1 with out_ready = 1 -> out_valid reproduces the pattern delayed by 2 cycles; data is correct per transfer.
- Bubble collapse: out_ready = 0, one transfer in stage 1, stage 0 empty, in_valid = 1 -> in_ready = 1 and stage 0 fills; next cycle in_ready = 0.
- Parameter variants: SEL_W = 2, DATA_W = 1 (latency 1, all 4 lanes) and SEL_W = 6, DATA_W = 16 (latency 3, random sel/data vs. reference model, 10k transfers, random out_ready) -> zero mismatches.
